mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder serving the processor's instruction-fetch (IM) and data (DM) ports from one shared single-port storage array, using the same active-low `wen`/`oen` request protocol the processor and bench drive. It arbitrates between a bench preload port, the DM port and the IM port, and enforces DM priority with bounded IM starvation. Each read returns data with one-cycle latency. It sits between the RISC core (or bench) and the storage array, replacing separate IM/DM memory models.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, address width of all ports
- `ADDR_DEPTH`, 2048, number of words in the storage array
- `STARVE_LIMIT`, 4, consecutive IM stall cycles before IM is forced to priority
- `clk  in  1  clock; all state updates on rising edge`
- `rst  in  1  reset; synchronous and active-high`
- `ld_en  in  1  preload write strobe, active-high`
- `ld_addr  in  ADDR_WIDTH  preload word address`
- `ld_data  in  DATA_WIDTH  preload data`
- `im_addr  in  ADDR_WIDTH  instruction word address`
- `im_oen  in  1  instruction read request, active-low`
- `im_dataout  out  DATA_WIDTH  instruction read data`
- `im_valid  out  1  im_dataout valid this cycle`
- `im_stall  out  1  IM request not accepted this cycle; hold request`
- `dm_addr  in  ADDR_WIDTH  data word address`
- `dm_wen  in  1  data write request, active-low`
- `dm_oen  in  1  data read request, active-low`
- `dm_datain  in  DATA_WIDTH  data write value`
- `dm_dataout  out  DATA_WIDTH  data read value`
- `dm_valid  out  1  dm_dataout valid this cycle`
- `dm_stall  out  1  DM request not accepted this cycle; hold request`
- `addr_err  out  1  one-cycle pulse: accepted access had addr >= ADDR_DEPTH`

## Operation
- Priority per cycle: `ld_en` > granted port > other port. Exactly one access is performed per cycle.
- Arbiter FSM has two states:
  - DM_PRI (reset state): DM is granted over IM.
  - IM_PRI: IM is granted over DM.
- Starvation counter `starve_cnt` (0..STARVE_LIMIT-1):
  - Increments each cycle an IM request is stalled.
  - Clears when IM is granted or no IM request is present.
- Transitions:
  - DM_PRI -> IM_PRI when IM is stalled while `starve_cnt == STARVE_LIMIT-1`.
  - IM_PRI -> DM_PRI on the cycle IM is granted. `starve_cnt` is cleared.
- A preload cycle stalls both ports. The stall counts toward IM starvation.
- Stall outputs are combinational from the current inputs and FSM state:
  - `im_stall = !im_oen && (ld_en || DM granted)`
  - `dm_stall = (!dm_wen || !dm_oen) && (ld_en || IM granted)`
- DM request with both `dm_wen=0` and `dm_oen=0`:
  - Write and read are performed in one cycle.
  - Read-first: `dm_dataout` returns the old word.
- Addresses `>= ADDR_DEPTH`:
  - Write is ignored.
  - Read returns 0 with valid asserted.
  - `addr_err` pulses the following cycle.
- Only `addr % 2^clog2(ADDR_DEPTH)` bits index the array. There is no wrap for out-of-range addresses; they are errored as above.
- Reset:
  - Clears all outputs to 0, FSM to DM_PRI, and `starve_cnt` to 0.
  - Does NOT clear array contents.
  - A read accepted in the reset cycle produces no valid.

## Timing
- Requests are sampled on the rising edge ending cycle N. Read data and valid are registered and visible for all of cycle N+1. Read latency is 1 cycle.
- `*_valid` is a single-cycle pulse per accepted read. `*_dataout` holds its last value when valid is low.
- A write accepted in cycle N is visible to any read accepted in cycle N+1 or later.
- A stalled initiator must hold address, data and strobes stable until stall deasserts. The request is accepted in the first cycle with stall low.
- Worst-case IM wait under continuous DM traffic: STARVE_LIMIT stall cycles, then a grant. Preload cycles can extend this.

## Structure
- Shared package `mem_pkg`:
  - width/depth constants
  - arbiter state enum {DM_PRI, IM_PRI}
  - active-low strobe constants `REQ_ON=1'b0`, `REQ_OFF=1'b1`
- Sub-module `mem_array`:
  - single-port synchronous RAM, read-first
  - inputs: `we`, `addr`, `wdata`; output: `rdata`
- The top level contains the arbiter FSM, starvation counter, stall/valid logic and range check.

## Test plan
- Preload `ld_en` writes 0xDEADBEEF at addr 5, then IM read addr 5 -> `im_valid=1` with `im_dataout=0xDEADBEEF` exactly one cycle later, `im_stall=0`.
- Same-cycle DM write 0x12 to addr 7 and IM read addr 7 -> `im_stall=1` for one cycle; IM accepted next cycle returns 0x12.
- DM reads on every cycle with a continuous IM request -> `im_stall` high for exactly 4 cycles, then `dm_stall=1` for one cycle while IM is served, then DM priority resumes.
- DM `wen=0,oen=0` at addr 3 holding 0x1, `datain=0x2` -> `dm_dataout=0x1`; subsequent read -> 0x2.
- DM read addr 2048 -> `dm_valid=1`, `dm_dataout=0`, `addr_err` pulse; a write to addr 2048 leaves addr 0 unchanged.
- `rst` asserted during an accepted read, with array preloaded -> `dm_valid` and `im_valid` stay 0, all outputs 0, FSM back to DM_PRI; post-reset read returns the preloaded data.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the IM/DM memory responder.
// Holds default widths/depth, the arbiter state encoding and the
// active-low request strobe levels used by the processor-side ports.
package mem_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int DEPTH      = 2048;
  localparam int STARVE_LIM = 4;

  // Request strobes (wen/oen) are active-low on the processor side.
  localparam logic REQ_ON  = 1'b0;
  localparam logic REQ_OFF = 1'b1;

  // Which port wins when IM and DM both request in the same cycle.
  typedef enum logic {
    DM_PRI = 1'b0,
    IM_PRI = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: bundles the preload, IM and DM request/response signals.
// master modport = initiator side (core or bench): drives requests, sees data/stall.
// slave modport  = responder side (mem_responder): sees requests, drives data/stall.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
);

  // Preload port (active-high strobe, never stalled)
  logic                  ld_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;

  // Instruction-fetch port
  logic [ADDR_WIDTH-1:0] im_addr;
  logic                  im_oen;
  logic [DATA_WIDTH-1:0] im_dataout;
  logic                  im_valid;
  logic                  im_stall;

  // Data port
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic                  dm_wen;
  logic                  dm_oen;
  logic [DATA_WIDTH-1:0] dm_datain;
  logic [DATA_WIDTH-1:0] dm_dataout;
  logic                  dm_valid;
  logic                  dm_stall;

  // Range error pulse
  logic                  addr_err;

  modport master (
    output ld_en, ld_addr, ld_data,
    output im_addr, im_oen,
    input  im_dataout, im_valid, im_stall,
    output dm_addr, dm_wen, dm_oen, dm_datain,
    input  dm_dataout, dm_valid, dm_stall,
    input  addr_err
  );

  modport slave (
    input  ld_en, ld_addr, ld_data,
    input  im_addr, im_oen,
    output im_dataout, im_valid, im_stall,
    input  dm_addr, dm_wen, dm_oen, dm_datain,
    output dm_dataout, dm_valid, dm_stall,
    output addr_err
  );

endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, read-first, one access per cycle.
// Ports: clk; we (write enable), addr (word index), wdata; rdata (registered,
//        returns the word as it was before any same-cycle write). No reset.
module mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_DEPTH = 2048,
  localparam int IDX_W     = $clog2(ADDR_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  // Contents are deliberately not reset so preloaded images survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: serves IM and DM from one shared single-port array, with a
//   bench preload port. Priority: preload > granted port > other port.
// Ports: clk, rst (sync, active-high); bus (mem_responder_if.slave) carrying
//   preload, IM and DM requests, read data/valid, stalls and addr_err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_W,
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int ADDR_DEPTH   = DEPTH,
  parameter int STARVE_LIMIT = STARVE_LIM
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(ADDR_DEPTH);
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);
  // One extra bit so the depth itself fits even when it equals 2^ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(ADDR_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e            state_q;
  logic [CNT_W-1:0]      starve_cnt_q;

  logic                  im_vld_q,   im_vld_d;
  logic                  dm_vld_q,   dm_vld_d;
  logic                  rd_oor_q,   rd_oor_d;
  logic                  addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0] im_hold_q,  im_hold_d;
  logic [DATA_WIDTH-1:0] dm_hold_q,  dm_hold_d;

  // ---------------------------------------------------------------------------
  // Request decode and arbitration
  // ---------------------------------------------------------------------------
  logic im_req, dm_wr, dm_rd, dm_req;
  logic dm_grant, im_grant;
  logic im_stall, dm_stall;

  always_comb begin
    im_req = (bus.im_oen == REQ_ON);
    dm_wr  = (bus.dm_wen == REQ_ON);
    dm_rd  = (bus.dm_oen == REQ_ON);
    dm_req = dm_wr || dm_rd;

    // Preload steals the array; otherwise the favoured port wins a conflict.
    dm_grant = !bus.ld_en && dm_req && ((state_q == DM_PRI) || !im_req);
    im_grant = !bus.ld_en && im_req && !dm_grant;

    im_stall = im_req && (bus.ld_en || dm_grant);
    dm_stall = dm_req && (bus.ld_en || im_grant);
  end

  // ---------------------------------------------------------------------------
  // Array access mux: exactly one access per cycle
  // ---------------------------------------------------------------------------
  logic                  acc_vld;
  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_in_range;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    acc_vld   = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (bus.ld_en) begin
      acc_vld   = 1'b1;
      acc_wr    = 1'b1;
      acc_addr  = bus.ld_addr;
      acc_wdata = bus.ld_data;
    end else if (dm_grant) begin
      acc_vld   = 1'b1;
      acc_wr    = dm_wr;
      acc_addr  = bus.dm_addr;
      acc_wdata = bus.dm_datain;
    end else if (im_grant) begin
      acc_vld   = 1'b1;
      acc_addr  = bus.im_addr;
    end

    // Out-of-range addresses must not alias onto low words: full-width compare.
    acc_in_range = ({1'b0, acc_addr} < DEPTH_X);
    ram_we       = acc_vld && acc_wr && acc_in_range;
  end

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_DEPTH (ADDR_DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_addr[IDX_W-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    im_vld_d   = im_grant;
    dm_vld_d   = dm_grant && dm_rd;
    // Only one read can be in flight, so a single out-of-range flag suffices.
    rd_oor_d   = !acc_in_range;
    addr_err_d = acc_vld && !acc_in_range;

    rd_word   = rd_oor_q ? '0 : ram_rdata;
    // The RAM output register changes on every access, so each port keeps
    // its own copy to present a stable value between its valid pulses.
    im_hold_d = im_vld_q ? rd_word : im_hold_q;
    dm_hold_d = dm_vld_q ? rd_word : dm_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_vld_q   <= 1'b0;
      dm_vld_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      addr_err_q <= 1'b0;
      im_hold_q  <= '0;
      dm_hold_q  <= '0;
    end else begin
      im_vld_q   <= im_vld_d;
      dm_vld_q   <= dm_vld_d;
      rd_oor_q   <= rd_oor_d;
      addr_err_q <= addr_err_d;
      im_hold_q  <= im_hold_d;
      dm_hold_q  <= dm_hold_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbiter FSM and IM starvation counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DM_PRI;
      starve_cnt_q <= '0;
    end else begin
      case (state_q)
        DM_PRI:  if (im_stall && (starve_cnt_q == CNT_MAX)) state_q <= IM_PRI;
        IM_PRI:  if (im_grant) state_q <= DM_PRI;
        default: state_q <= DM_PRI;
      endcase

      // Saturates while IM keeps waiting (preload can stall it in IM_PRI).
      if (im_stall) begin
        if (starve_cnt_q != CNT_MAX) begin
          starve_cnt_q <= starve_cnt_q + 1'b1;
        end
      end else begin
        starve_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.im_stall   = im_stall;
  assign bus.dm_stall   = dm_stall;
  assign bus.im_valid   = im_vld_q;
  assign bus.dm_valid   = dm_vld_q;
  assign bus.im_dataout = im_hold_d;
  assign bus.dm_dataout = dm_hold_d;
  assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven directed vectors, hand sequences for
// starvation and reset, then randomized traffic against a reference model.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_responder_if bus ();

  mem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Values captured each cycle
  logic        s_ims, s_dms, s_imv, s_dmv, s_err;
  logic [31:0] s_imd, s_dmd;

  typedef struct {
    logic        ld;    logic [31:0] ld_a;  logic [31:0] ld_d;
    logic        im_r;  logic [31:0] im_a;
    logic        dm_w;  logic        dm_r;  logic [31:0] dm_a; logic [31:0] dm_d;
    logic        e_ims; logic        e_dms;
    logic        e_imv; logic [31:0] e_imd;
    logic        e_dmv; logic [31:0] e_dmd;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(
      input logic ld, input logic [31:0] ld_a, input logic [31:0] ld_d,
      input logic im_r, input logic [31:0] im_a,
      input logic dm_w, input logic dm_r, input logic [31:0] dm_a, input logic [31:0] dm_d,
      input logic e_ims, input logic e_dms,
      input logic e_imv, input logic [31:0] e_imd,
      input logic e_dmv, input logic [31:0] e_dmd, input logic e_err);
    vec_t v;
    v.ld = ld; v.ld_a = ld_a; v.ld_d = ld_d; v.im_r = im_r; v.im_a = im_a;
    v.dm_w = dm_w; v.dm_r = dm_r; v.dm_a = dm_a; v.dm_d = dm_d;
    v.e_ims = e_ims; v.e_dms = e_dms; v.e_imv = e_imv; v.e_imd = e_imd;
    v.e_dmv = e_dmv; v.e_dmd = e_dmd; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [31:0] lda, input logic [31:0] ldd,
                       input logic imr, input logic [31:0] ima,
                       input logic dmw, input logic dmr, input logic [31:0] dma,
                       input logic [31:0] dmd);
    bus.ld_en     = ld;
    bus.ld_addr   = lda;
    bus.ld_data   = ldd;
    bus.im_oen    = imr ? REQ_ON : REQ_OFF;
    bus.im_addr   = ima;
    bus.dm_wen    = dmw ? REQ_ON : REQ_OFF;
    bus.dm_oen    = dmr ? REQ_ON : REQ_OFF;
    bus.dm_addr   = dma;
    bus.dm_datain = dmd;
  endtask

  // Stalls are combinational: sample mid-cycle. Registered outputs: #1 after edge.
  task automatic cycle();
    @(negedge clk);
    s_ims = bus.im_stall;
    s_dms = bus.dm_stall;
    @(posedge clk);
    #1;
    s_imv = bus.im_valid;  s_imd = bus.im_dataout;
    s_dmv = bus.dm_valid;  s_dmd = bus.dm_dataout;
    s_err = bus.addr_err;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: word store, per-port last-returned data, IM wait length.
  // IM wins a conflict once it has already waited STARVE_LIM cycles in a row.
  // ---------------------------------------------------------------------------
  logic [31:0] mm [16];
  logic [31:0] m_imh, m_dmh;
  int          m_wait;

  task automatic rstep(input logic ld, input logic [31:0] lda, input logic [31:0] ldd,
                       input logic imr, input logic [31:0] ima,
                       input logic dmw, input logic dmr, input logic [31:0] dma,
                       input logic [31:0] dmd, input string tag,
                       output logic ims, output logic dms);
    logic dmq, imv, dmv, err, oor;
    logic [31:0] a, rv;
    dmq = dmw || dmr;
    ims = 1'b0; dms = 1'b0; imv = 1'b0; dmv = 1'b0; err = 1'b0; rv = '0;
    if (ld) begin
      ims = imr; dms = dmq;
    end else if (imr && dmq) begin
      ims = (m_wait < STARVE_LIM);
      dms = !ims;
    end
    drive(ld, lda, ldd, imr, ima, dmw, dmr, dma, dmd);
    cycle();
    if (ld) begin
      if (lda < 32'd2048) mm[lda[3:0]] = ldd;
      else err = 1'b1;
    end else if (dmq && !dms) begin
      a = dma; oor = (a >= 32'd2048); err = oor;
      rv = oor ? 32'h0 : mm[a[3:0]];
      if (dmw && !oor) mm[a[3:0]] = dmd;
      if (dmr) begin dmv = 1'b1; m_dmh = rv; end
    end else if (imr && !ims) begin
      a = ima; oor = (a >= 32'd2048); err = oor;
      rv = oor ? 32'h0 : mm[a[3:0]];
      imv = 1'b1; m_imh = rv;
    end
    m_wait = (imr && ims) ? m_wait + 1 : 0;
    chk({tag, "_im_stall"}, {31'b0, s_ims}, {31'b0, ims});
    chk({tag, "_dm_stall"}, {31'b0, s_dms}, {31'b0, dms});
    chk({tag, "_im_valid"}, {31'b0, s_imv}, {31'b0, imv});
    chk({tag, "_dm_valid"}, {31'b0, s_dmv}, {31'b0, dmv});
    chk({tag, "_addr_err"}, {31'b0, s_err}, {31'b0, err});
    chk({tag, "_im_data"},  s_imd, m_imh);
    chk({tag, "_dm_data"},  s_dmd, m_dmh);
  endtask

  function automatic logic [31:0] raddr();
    if ($urandom_range(0, 9) == 0) return 32'd2048 + $urandom_range(0, 3);
    return $urandom_range(0, 15);
  endfunction

  vec_t tbl [16];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic imr, dmw, dmr, ld, ims, dms, im_pend, dm_pend;
    logic [31:0] ima, dma, dmd, lda, ldd;
    int k;

    tbl[0]  = mk(1,5,32'hDEADBEEF, 0,0, 0,0,0,0,        0,0, 0,32'h0,        0,32'h0,    0);
    tbl[1]  = mk(0,0,0, 1,5, 0,0,0,0,                    0,0, 1,32'hDEADBEEF, 0,32'h0,    0);
    tbl[2]  = mk(1,3,32'h1, 0,0, 0,0,0,0,                0,0, 0,32'hDEADBEEF, 0,32'h0,    0);
    tbl[3]  = mk(1,0,32'hA5A5, 0,0, 0,0,0,0,             0,0, 0,32'hDEADBEEF, 0,32'h0,    0);
    tbl[4]  = mk(0,0,0, 1,7, 1,0,7,32'h12,               1,0, 0,32'hDEADBEEF, 0,32'h0,    0);
    tbl[5]  = mk(0,0,0, 1,7, 0,0,0,0,                    0,0, 1,32'h12,       0,32'h0,    0);
    tbl[6]  = mk(0,0,0, 0,0, 1,1,3,32'h2,                0,0, 0,32'h12,       1,32'h1,    0);
    tbl[7]  = mk(0,0,0, 0,0, 0,1,3,0,                    0,0, 0,32'h12,       1,32'h2,    0);
    tbl[8]  = mk(0,0,0, 0,0, 0,1,2048,0,                 0,0, 0,32'h12,       1,32'h0,    1);
    tbl[9]  = mk(0,0,0, 0,0, 1,0,2048,32'hBAD,           0,0, 0,32'h12,       0,32'h0,    1);
    tbl[10] = mk(0,0,0, 0,0, 0,1,0,0,                    0,0, 0,32'h12,       1,32'hA5A5, 0);
    tbl[11] = mk(0,0,0, 1,2049, 0,0,0,0,                 0,0, 1,32'h0,        0,32'hA5A5, 1);
    tbl[12] = mk(1,9,32'h99, 1,9, 0,0,0,0,               1,0, 0,32'h0,        0,32'hA5A5, 0);
    tbl[13] = mk(0,0,0, 1,9, 0,0,0,0,                    0,0, 1,32'h99,       0,32'hA5A5, 0);
    tbl[14] = mk(0,0,0, 1,9, 0,1,3,0,                    1,0, 0,32'h99,       1,32'h2,    0);
    tbl[15] = mk(0,0,0, 1,9, 0,0,0,0,                    0,0, 1,32'h99,       0,32'h2,    0);

    // Reset state
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("rst_im_valid", {31'b0, s_imv}, 32'h0);
    chk("rst_dm_valid", {31'b0, s_dmv}, 32'h0);
    chk("rst_im_data",  s_imd, 32'h0);
    chk("rst_dm_data",  s_dmd, 32'h0);
    chk("rst_addr_err", {31'b0, s_err}, 32'h0);
    chk("rst_im_stall", {31'b0, s_ims}, 32'h0);
    chk("rst_dm_stall", {31'b0, s_dms}, 32'h0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].ld, tbl[i].ld_a, tbl[i].ld_d, tbl[i].im_r, tbl[i].im_a,
            tbl[i].dm_w, tbl[i].dm_r, tbl[i].dm_a, tbl[i].dm_d);
      cycle();
      chk($sformatf("tbl%0d_im_stall", i), {31'b0, s_ims}, {31'b0, tbl[i].e_ims});
      chk($sformatf("tbl%0d_dm_stall", i), {31'b0, s_dms}, {31'b0, tbl[i].e_dms});
      chk($sformatf("tbl%0d_im_valid", i), {31'b0, s_imv}, {31'b0, tbl[i].e_imv});
      chk($sformatf("tbl%0d_im_data", i),  s_imd, tbl[i].e_imd);
      chk($sformatf("tbl%0d_dm_valid", i), {31'b0, s_dmv}, {31'b0, tbl[i].e_dmv});
      chk($sformatf("tbl%0d_dm_data", i),  s_dmd, tbl[i].e_dmd);
      chk($sformatf("tbl%0d_addr_err", i), {31'b0, s_err}, {31'b0, tbl[i].e_err});
    end

    // Starvation: DM reads every cycle, IM requests continuously.
    // Expect 4 IM stalls, one IM grant (DM stalled), then the pattern repeats.
    drive(0, 0, 0, 1, 5, 0, 1, 3, 0);
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk($sformatf("starve%0d_im_stall", c), {31'b0, s_ims}, (c % 5 != 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve%0d_dm_stall", c), {31'b0, s_dms}, (c % 5 == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve%0d_im_valid", c), {31'b0, s_imv}, (c % 5 == 4) ? 32'h1 : 32'h0);
      chk($sformatf("starve%0d_dm_valid", c), {31'b0, s_dmv}, (c % 5 != 4) ? 32'h1 : 32'h0);
      if (c % 5 == 4) chk($sformatf("starve%0d_im_data", c), s_imd, 32'hDEADBEEF);
      else            chk($sformatf("starve%0d_dm_data", c), s_dmd, 32'h2);
    end

    // Reset while IM is favoured and its read is being accepted.
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk($sformatf("prerst%0d_im_stall", c), {31'b0, s_ims}, 32'h1);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("inrst_im_stall", {31'b0, s_ims}, 32'h0);
    chk("inrst_dm_stall", {31'b0, s_dms}, 32'h1);
    chk("postrst_im_valid", {31'b0, s_imv}, 32'h0);
    chk("postrst_dm_valid", {31'b0, s_dmv}, 32'h0);
    chk("postrst_im_data",  s_imd, 32'h0);
    chk("postrst_dm_data",  s_dmd, 32'h0);
    chk("postrst_addr_err", {31'b0, s_err}, 32'h0);
    cycle();
    chk("postrst_dmpri_im_stall", {31'b0, s_ims}, 32'h1);
    chk("postrst_dmpri_dm_stall", {31'b0, s_dms}, 32'h0);
    chk("postrst_dm_rd_valid",    {31'b0, s_dmv}, 32'h1);
    chk("postrst_dm_rd_data",     s_dmd, 32'h2);
    drive(0, 0, 0, 1, 5, 0, 0, 0, 0);
    cycle();
    chk("postrst_im_rd_stall", {31'b0, s_ims}, 32'h0);
    chk("postrst_im_rd_valid", {31'b0, s_imv}, 32'h1);
    chk("postrst_im_rd_data",  s_imd, 32'hDEADBEEF);

    // Randomized traffic against the reference model.
    m_imh = 32'hDEADBEEF; m_dmh = 32'h2; m_wait = 0;
    for (int i = 0; i < 16; i++) begin
      rstep(1, i, $urandom, 0, 0, 0, 0, 0, 0, $sformatf("pre%0d", i), ims, dms);
    end
    im_pend = 1'b0; dm_pend = 1'b0;
    imr = 0; ima = 0; dmw = 0; dmr = 0; dma = 0; dmd = 0;
    for (int n = 0; n < 500; n++) begin
      if (!im_pend) begin
        imr = ($urandom_range(0, 1) == 1);
        ima = raddr();
      end
      if (!dm_pend) begin
        k   = $urandom_range(0, 3);
        dmw = (k == 1) || (k == 3);
        dmr = (k == 2) || (k == 3);
        dma = raddr();
        dmd = $urandom;
      end
      ld  = ($urandom_range(0, 7) == 0);
      lda = $urandom_range(0, 15);
      ldd = $urandom;
      rstep(ld, lda, ldd, imr, ima, dmw, dmr, dma, dmd, $sformatf("rnd%0d", n), ims, dms);
      im_pend = imr && ims;
      dm_pend = (dmw || dmr) && dms;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
